// File: rtl/fifo_page_reader.sv
// fifo_page_reader: drains LEN words from a non-FWFT COREFIFO read port into a valid/ready stream (optional FIFO_PAGE_READER_STALL_CNT_EN adds an empty-stall counter)
module fifo_page_reader #(
  parameter int DWIDTH     = 18,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 4,
  parameter int LEN_W      = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              FIFO_EMPTY,
  output logic              FIFO_RE,
  input  logic [DWIDTH-1:0] FIFO_Q,
  output logic [DWIDTH-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       STALL_CNT
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE_ST = 2'd3;
  localparam int PW = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = CW + 2;
  logic [1:0]            state;
  logic [LEN_W-1:0]      len, issued, out_cnt;
  logic [RD_LATENCY-1:0] pipe;
  logic [DWIDTH-1:0]     mem [SKID_DEPTH];
  logic [PW-1:0]         wp, rp;
  logic [CW-1:0]         cnt;
  logic [OW-1:0]         occ;
  logic                  pop, push;
  assign OUT_VALID = cnt != '0;
  assign OUT_DATA  = OUT_VALID ? mem[rp] : '0;
  assign OUT_LAST  = OUT_VALID && out_cnt == len - 1'b1;
  assign BUSY      = state == RUN || state == DRAIN;
  // Credit check: skid entries plus words still in the read pipe must fit after this cycle's pop
  always_comb begin
    pop     = OUT_VALID & OUT_READY;
    push    = pipe[RD_LATENCY-1];
    occ     = OW'(cnt) + OW'($countones(pipe)) - OW'(pop);
    FIFO_RE = state == RUN && !FIFO_EMPTY && issued < len && occ < OW'(SKID_DEPTH);
  end
  // Transfer FSM, issue/output counters and read-latency valid pipe
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      len     <= '0;
      issued  <= '0;
      out_cnt <= '0;
      pipe    <= '0;
      DONE    <= 1'b0;
    end else begin
      DONE <= state == DONE_ST;
      pipe <= RD_LATENCY'({pipe, FIFO_RE});
      if (FIFO_RE) issued <= issued + 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
      if (state == IDLE && START) begin
        len     <= LEN;
        issued  <= '0;
        out_cnt <= '0;
        state   <= LEN != '0 ? RUN : DONE_ST;
      end else if (state == RUN && FIFO_RE && issued == len - 1'b1) state <= DRAIN;
      else if (state == DRAIN && pop && OUT_LAST) state <= DONE_ST;
      else if (state == DONE_ST) state <= IDLE;
    end
  end
  // Skid pointers and occupancy; push and pop in one cycle leave the count unchanged
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp == PW'(SKID_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(SKID_DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // Skid storage captures FIFO_Q when its pipe tap arrives
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= FIFO_Q;
  end
`ifdef FIFO_PAGE_READER_STALL_CNT_EN
  // Count RUN cycles starved by an empty FIFO, saturating
  always_ff @(posedge CLK) begin
    if (RESET || (state == IDLE && START)) STALL_CNT <= '0;
    else if (state == RUN && issued < len && FIFO_EMPTY && STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 1'b1;
  end
`else
  assign STALL_CNT = 16'h0000;
`endif
endmodule

// File: tb/tb_fifo_page_reader.sv
// tb_fifo_page_reader: randomized scoreboard bench for fifo_page_reader with a queue-based COREFIFO model
module tb_fifo_page_reader;
  localparam int DW = 18;
  localparam int LW = 11;
  logic          CLK = 0, RESET = 1, START = 0, FIFO_EMPTY = 1, OUT_READY = 0;
  logic [LW-1:0] LEN = '0;
  logic [DW-1:0] FIFO_Q = '0;
  logic          FIFO_RE, OUT_VALID, OUT_LAST, BUSY, DONE;
  logic [DW-1:0] OUT_DATA;
  logic [15:0]   STALL_CNT;
  int checks = 0, fails = 0;
  int re_cnt = 0, hs_cnt = 0, done_cnt = 0, underflow = 0, pos = 0, rdy_mode = 0;
  logic [DW-1:0] fq[$], src[$];
  int xfer[$];
  logic held = 0, hl = 0;
  logic [DW-1:0] hd = '0;

  fifo_page_reader dut (
    .CLK(CLK), .RESET(RESET), .START(START), .LEN(LEN), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RE(FIFO_RE), .FIFO_Q(FIFO_Q), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .BUSY(BUSY), .DONE(DONE), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // COREFIFO model: non-FWFT, one-cycle read latency, registered EMPTY
  always @(posedge CLK) begin
    if (FIFO_RE) begin
      if (fq.size() == 0) underflow++;
      else begin
        FIFO_Q <= fq.pop_front();
        re_cnt++;
      end
    end
    FIFO_EMPTY <= (fq.size() == 0);
  end

  // Ready driver: 0 = stalled, 1 = always ready, 2 = random
  always @(posedge CLK) begin
    #2;
    OUT_READY = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
  end

  // Monitor: stream rules and in-order scoreboard against the words the model FIFO was given
  always @(negedge CLK) begin
    if (RESET) held = 0;
    else begin
      if (!OUT_VALID) chk("last_without_valid", OUT_LAST, 0);
      if (held) begin
        chk("hold_valid", OUT_VALID, 1);
        chk("hold_data", OUT_DATA, hd);
        chk("hold_last", OUT_LAST, hl);
      end
      held = OUT_VALID && !OUT_READY;
      hd = OUT_DATA;
      hl = OUT_LAST;
      if (OUT_VALID && OUT_READY) begin
        hs_cnt++;
        if (xfer.size() == 0 || src.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          chk("data", OUT_DATA, src.pop_front());
          chk("last", OUT_LAST, pos == xfer[0] - 1);
          pos++;
          if (pos == xfer[0]) begin
            void'(xfer.pop_front());
            pos = 0;
          end
        end
      end
      if (DONE) done_cnt++;
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(logic [DW-1:0] w);
    fq.push_back(w);
    src.push_back(w);
  endtask

  task automatic start(int n, bit accepted);
    START = 1;
    LEN = LW'(n);
    if (accepted && n > 0) xfer.push_back(n);
    cyc();
    START = 0;
  endtask

  task automatic wait_done(int target);
    int k = 0;
    while (done_cnt < target && k < 2000) begin
      cyc();
      k++;
    end
    chk("done_timeout", done_cnt >= target, 1);
  endtask

  task automatic flush();
    fq.delete();
    src.delete();
    xfer.delete();
    pos = 0;
  endtask

  task automatic outputs_zero(string nm);
    @(negedge CLK);
    chk({nm, "_re"}, FIFO_RE, 0);
    chk({nm, "_valid"}, OUT_VALID, 0);
    chk({nm, "_data"}, OUT_DATA, 0);
    chk({nm, "_last"}, OUT_LAST, 0);
    chk({nm, "_busy"}, BUSY, 0);
    chk({nm, "_done"}, DONE, 0);
    chk({nm, "_stall"}, STALL_CNT, 0);
    cyc();
  endtask

  initial begin
    int d, r0, h0, k, n;
    cyc(3);
    RESET = 0;
    outputs_zero("reset");

    // Preloaded 1..4, always ready: fixed cycle timeline
    for (int i = 1; i <= 4; i++) push(DW'(i));
    rdy_mode = 1;
    cyc(3);
    d = done_cnt;
    START = 1;
    LEN = LW'(4);
    xfer.push_back(4);
    for (int i = 1; i <= 9; i++) begin
      @(posedge CLK);
      #1 START = 0;
      @(negedge CLK);
      chk($sformatf("t1_re_c%0d", i), FIFO_RE, i >= 1 && i <= 4);
      chk($sformatf("t1_valid_c%0d", i), OUT_VALID, i >= 3 && i <= 6);
      if (i >= 3 && i <= 6) chk($sformatf("t1_data_c%0d", i), OUT_DATA, i - 2);
      chk($sformatf("t1_done_c%0d", i), DONE, i == 8);
    end
    cyc();
    chk("t1_done_count", done_cnt, d + 1);

    // Backpressure: credit limit stops issue at the skid depth
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    rdy_mode = 0;
    cyc(3);
    r0 = re_cnt;
    d = done_cnt;
    start(8, 1);
    cyc(15);
    chk("t2_re_under_bp", re_cnt - r0, 4);
    chk("t2_busy", BUSY, 1);
    rdy_mode = 2;
    wait_done(d + 1);
    chk("t2_fifo_drained", fq.size(), 0);

    // Starved FIFO: one word every five cycles
    rdy_mode = 1;
    cyc(2);
    d = done_cnt;
    start(3, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(5);
      push(DW'($urandom));
    end
    wait_done(d + 1);
`ifdef FIFO_PAGE_READER_STALL_CNT_EN
    chk("t3_stall_nonzero", STALL_CNT > 0, 1);
`else
    chk("t3_stall_zero", STALL_CNT, 0);
`endif

    // Zero-length transfer
    cyc(2);
    r0 = re_cnt;
    d = done_cnt;
    START = 1;
    LEN = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK);
      #1 START = 0;
      @(negedge CLK);
      chk($sformatf("t4_re_c%0d", i), FIFO_RE, 0);
      chk($sformatf("t4_valid_c%0d", i), OUT_VALID, 0);
      chk($sformatf("t4_busy_c%0d", i), BUSY, 0);
      chk($sformatf("t4_done_c%0d", i), DONE, i == 2);
    end
    cyc();
    chk("t4_no_re", re_cnt - r0, 0);
    chk("t4_done_count", done_cnt, d + 1);

    // Reset mid-transfer, then a fresh transfer
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    cyc(3);
    h0 = hs_cnt;
    d = done_cnt;
    start(6, 1);
    k = 0;
    while (hs_cnt < h0 + 2 && k < 200) begin
      cyc();
      k++;
    end
    chk("t5_two_words_timeout", hs_cnt >= h0 + 2, 1);
    RESET = 1;
    rdy_mode = 0;
    cyc();
    RESET = 0;
    flush();
    outputs_zero("t5_after_reset");
    cyc(3);
    chk("t5_no_done", done_cnt, d);
    push(DW'($urandom));
    push(DW'($urandom));
    rdy_mode = 1;
    cyc(3);
    start(2, 1);
    wait_done(d + 1);

    // START during a transfer is ignored
    for (int i = 0; i < 9; i++) push(DW'($urandom));
    rdy_mode = 2;
    cyc(3);
    d = done_cnt;
    start(5, 1);
    cyc(3);
    start(9, 0);
    wait_done(d + 1);
    cyc(12);
    chk("t6_single_done", done_cnt, d + 1);
    chk("t6_words_left", fq.size(), 4);
    flush();
    cyc(3);

    // Random transfers with random data, gaps and backpressure
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n / 2; i++) push(DW'($urandom));
      cyc(3);
      d = done_cnt;
      start(n, 1);
      for (int i = n / 2; i < n; i++) begin
        cyc($urandom_range(0, 3));
        push(DW'($urandom));
      end
      wait_done(d + 1);
      cyc(2);
    end

    chk("no_re_when_empty", underflow, 0);
    chk("scoreboard_xfer_empty", xfer.size(), 0);
    chk("scoreboard_src_empty", src.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
